pito_irq_dispatch: RTL and testbench

- Arbitrates MVU interrupt events from NUM_SRC sources.
- Delivers each event into a per-hart interrupt queue of depth Q_DEPTH.
- Presents the head event to each hart as its MVU interrupt-pending level (MIP.MVIP, bit 16) plus a 32-bit payload.
- Sits between the MVU array and the pito CSR file; the hart pops an event by claiming it.

---
 rtl/pito_irq_dispatch.sv | 109 ++++++++++
 tb/tb_pito_irq_dispatch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pito_irq_dispatch.sv
// rtl/pito_irq_dispatch.sv - round-robin MVU interrupt arbiter feeding per-hart event queues
// Each hart sees its queue head as an MVIP level plus payload and pops it by claiming.
module pito_irq_dispatch #(
  parameter int NUM_SRC   = 8,
  parameter int NUM_HARTS = 8,
  parameter int HART_W    = $clog2(NUM_HARTS),
  parameter int Q_DEPTH   = 4,
  parameter int DATA_W    = 32,
  localparam int PTR_W    = $clog2(Q_DEPTH),
  localparam int CNT_W    = PTR_W + 1,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  input  logic [NUM_SRC*HART_W-1:0]    src_hart_i,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_HARTS-1:0]         hart_mie_i,
  input  logic [NUM_HARTS-1:0]         hart_claim_i,
  output logic [NUM_HARTS-1:0]         hart_irq_o,
  output logic [NUM_HARTS*DATA_W-1:0]  hart_data_o,
  output logic [NUM_HARTS*CNT_W-1:0]   q_count_o,
  output logic                         claim_err_o
);

  logic [DATA_W-1:0] mem   [NUM_HARTS][Q_DEPTH];
  logic [PTR_W-1:0]  head  [NUM_HARTS];
  logic [PTR_W-1:0]  tail  [NUM_HARTS];
  logic [CNT_W-1:0]  count [NUM_HARTS];
  logic [SRC_W-1:0]  rr;
  logic              claim_err_q;

  logic [NUM_SRC-1:0]   eligible;
  logic                 grant_vld;
  logic [SRC_W-1:0]     grant_idx;
  logic [HART_W-1:0]    grant_hart;
  logic [DATA_W-1:0]    grant_data;
  logic [NUM_HARTS-1:0] nonempty;
  logic [NUM_HARTS-1:0] push;
  logic [NUM_HARTS-1:0] pop;

  // Fullness uses registered count only: a same-cycle claim never frees a slot.
  always_comb begin
    eligible = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      eligible[s] = src_valid_i[s] && !rst &&
                    (count[src_hart_i[s*HART_W +: HART_W]] != CNT_W'(Q_DEPTH));
    end
  end

  always_comb begin
    int s;
    s           = 0;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    src_ready_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = (int'(rr) + i) % NUM_SRC;
      if (!grant_vld && eligible[s]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(s);
      end
    end
    if (grant_vld) src_ready_o[grant_idx] = 1'b1;
    grant_hart = src_hart_i[int'(grant_idx)*HART_W +: HART_W];
    grant_data = src_data_i[int'(grant_idx)*DATA_W +: DATA_W];
  end

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      nonempty[h] = (count[h] != '0);
      push[h]     = grant_vld && (grant_hart == HART_W'(h));
      pop[h]      = hart_claim_i[h] && nonempty[h];
      hart_irq_o[h] = nonempty[h] & hart_mie_i[h];
      hart_data_o[h*DATA_W +: DATA_W] = nonempty[h] ? mem[h][head[h]] : '0;
      q_count_o[h*CNT_W +: CNT_W]     = count[h];
    end
  end

  assign claim_err_o = claim_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr          <= '0;
      claim_err_q <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        head[h]  <= '0;
        tail[h]  <= '0;
        count[h] <= '0;
      end
    end else begin
      claim_err_q <= |(hart_claim_i & ~nonempty);
      if (grant_vld) begin
        rr <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (push[h]) begin
          mem[h][tail[h]] <= grant_data;
          tail[h]         <= tail[h] + PTR_W'(1);
        end
        if (pop[h]) head[h] <= head[h] + PTR_W'(1);
        if (push[h] && !pop[h])      count[h] <= count[h] + CNT_W'(1);
        else if (pop[h] && !push[h]) count[h] <= count[h] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pito_irq_dispatch.sv
// tb/tb_pito_irq_dispatch.sv - directed bench for pito_irq_dispatch with a queue-based reference model
module tb_pito_irq_dispatch;
  localparam int NS = 8, NH = 8, HW = 3, QD = 4, DW = 32, CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0]    src_valid = '0;
  logic [NS*HW-1:0] src_hart  = '0;
  logic [NS*DW-1:0] src_data  = '0;
  logic [NS-1:0]    src_ready;
  logic [NH-1:0]    mie   = '0;
  logic [NH-1:0]    claim = '0;
  logic [NH-1:0]    irq;
  logic [NH*DW-1:0] hdata;
  logic [NH*CW-1:0] qcnt;
  logic             claim_err;

  always #5 clk = ~clk;

  pito_irq_dispatch #(
    .NUM_SRC(NS), .NUM_HARTS(NH), .HART_W(HW), .Q_DEPTH(QD), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid_i(src_valid), .src_hart_i(src_hart), .src_data_i(src_data),
    .src_ready_o(src_ready),
    .hart_mie_i(mie), .hart_claim_i(claim),
    .hart_irq_o(irq), .hart_data_o(hdata), .q_count_o(qcnt),
    .claim_err_o(claim_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one FIFO per hart, a round-robin start index, a claim-error flag.
  logic [DW-1:0] mq [NH][$];
  int m_rr = 0;
  bit m_err = 1'b0;
  bit m_live = 1'b0;

  function automatic int hart_of(int s);
    return int'(src_hart[s*HW +: HW]);
  endfunction

  function automatic int m_pick();
    for (int i = 0; i < NS; i++) begin
      int s;
      s = (m_rr + i) % NS;
      if (src_valid[s] && mq[hart_of(s)].size() < QD) return s;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int h = 0; h < NH; h++) mq[h].delete();
      m_rr = 0;
      m_err = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      int g;
      bit e;
      g = m_pick();
      e = 1'b0;
      for (int h = 0; h < NH; h++) begin
        if (claim[h]) begin
          if (mq[h].size() == 0) e = 1'b1;
          else void'(mq[h].pop_front());
        end
      end
      if (g >= 0) begin
        mq[hart_of(g)].push_back(src_data[g*DW +: DW]);
        m_rr = (g + 1) % NS;
      end
      m_err = e;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      int g;
      logic [NS-1:0]    e_ready;
      logic [NH-1:0]    e_irq;
      logic [NH*DW-1:0] e_data;
      logic [NH*CW-1:0] e_cnt;
      g = rst ? -1 : m_pick();
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      for (int h = 0; h < NH; h++) begin
        e_irq[h] = (mq[h].size() != 0) && mie[h];
        e_data[h*DW +: DW] = (mq[h].size() != 0) ? mq[h][0] : '0;
        e_cnt[h*CW +: CW] = CW'(mq[h].size());
      end
      chk("model_ready", src_ready, e_ready);
      chk("model_irq", irq, e_irq);
      chk("model_data", hdata, e_data);
      chk("model_count", qcnt, e_cnt);
      chk("model_claim_err", claim_err, m_err);
    end
  end

  // One clock; drops valid for any source whose handshake completed at this edge.
  task automatic tick();
    logic [NS-1:0] acc;
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    src_valid = src_valid & ~acc;
  endtask

  task automatic set_src(input int s, input int h, input logic [DW-1:0] d);
    src_valid[s] = 1'b1;
    src_hart[s*HW +: HW] = HW'(h);
    src_data[s*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0;
    claim = '0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(int h);
    return qcnt[h*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] dat(int h);
    return hdata[h*DW +: DW];
  endfunction

  logic [NS-1:0] rr_seq [3];

  initial begin
    rr_seq[0] = 8'h01;
    rr_seq[1] = 8'h08;
    rr_seq[2] = 8'h80;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", qcnt, 0);
    chk("reset_irq", irq, 0);
    chk("reset_claim_err", claim_err, 0);

    // single event
    mie = 8'h04;
    set_src(0, 2, 32'hDEAD_BEEF);
    #1 chk("single_ready", src_ready, 8'h01);
    tick();
    #1;
    chk("single_irq", irq, 8'h04);
    chk("single_data", dat(2), 32'hDEAD_BEEF);
    chk("single_count", cnt(2), 1);
    claim[2] = 1'b1;
    tick();
    claim = '0;
    #1;
    chk("single_irq_after_claim", irq, 0);
    chk("single_count_after_claim", cnt(2), 0);

    // round-robin
    do_reset();
    mie = '1;
    for (int rep = 0; rep < 2; rep++) begin
      set_src(0, 0, 32'h100);
      set_src(3, 1, 32'h103);
      set_src(7, 2, 32'h107);
      for (int k = 0; k < 3; k++) begin
        #1 chk("rr_grant", src_ready, rr_seq[k]);
        tick();
      end
      #1 chk("rr_idle", src_ready, 0);
    end

    // backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_src(1, 5, DW'(i));
      #1 chk("bp_accept", src_ready, 8'h02);
      tick();
    end
    set_src(1, 5, 32'd5);
    #1;
    chk("bp_full_ready", src_ready, 0);
    chk("bp_full_count", cnt(5), 4);
    tick();
    #1;
    chk("bp_still_blocked", src_ready, 0);
    chk("bp_head_1", dat(5), 1);
    claim[5] = 1'b1;
    tick();
    claim = '0;
    #1;
    chk("bp_ready_after_claim", src_ready, 8'h02);
    chk("bp_count_after_claim", cnt(5), 3);
    tick();
    #1 chk("bp_refilled", cnt(5), 4);
    for (int v = 2; v <= 5; v++) begin
      #1 chk("bp_order", dat(5), DW'(v));
      claim[5] = 1'b1;
      tick();
      claim = '0;
    end
    #1 chk("bp_drained", cnt(5), 0);

    // full plus claim
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_src(2, 4, DW'(10 + i));
      tick();
    end
    set_src(2, 4, 32'd99);
    claim[4] = 1'b1;
    #1 chk("fc_no_grant", src_ready, 0);
    tick();
    claim = '0;
    #1;
    chk("fc_count_3", cnt(4), 3);
    chk("fc_grant_next", src_ready, 8'h04);
    tick();
    #1 chk("fc_count_4", cnt(4), 4);

    // gating and claim error
    do_reset();
    mie = '0;
    set_src(6, 6, 32'h60);
    tick();
    set_src(6, 6, 32'h61);
    tick();
    #1;
    chk("gate_irq_off", irq, 0);
    chk("gate_count", cnt(6), 2);
    mie = 8'h40;
    #1 chk("gate_irq_on", irq, 8'h40);
    claim[0] = 1'b1;
    tick();
    claim = '0;
    #1;
    chk("err_pulse", claim_err, 1);
    chk("err_count0", cnt(0), 0);
    tick();
    #1 chk("err_cleared", claim_err, 0);

    // reset mid-operation
    set_src(0, 1, 32'h10);
    set_src(2, 3, 32'h30);
    tick();
    tick();
    #1 chk("mid_pre_counts", {cnt(6), cnt(3), cnt(1)}, {3'd2, 3'd1, 3'd1});
    rst = 1'b1;
    set_src(4, 7, 32'h44);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_counts_zero", qcnt, 0);
    chk("mid_irq_zero", irq, 0);
    chk("mid_src4_ready", src_ready, 8'h10);
    tick();
    #1;
    chk("mid_src4_count", cnt(7), 1);
    chk("mid_src4_data", dat(7), 32'h44);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
